// File: rtl/ospi_pkg.sv
// Shared definitions for the octal-SPI target: opcodes, FSM states, status layout.
package ospi_pkg;

  localparam logic [7:0] OSPI_CMD_WRITE       = 8'h02;
  localparam logic [7:0] OSPI_CMD_READ        = 8'h03;
  localparam logic [7:0] OSPI_CMD_FAST_READ   = 8'h0B;
  localparam logic [7:0] OSPI_CMD_READ_STATUS = 8'h05;
  localparam logic [7:0] OSPI_CMD_WREN        = 8'h06;
  localparam logic [7:0] OSPI_CMD_WRDI        = 8'h04;

  localparam int WEL_BIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_STATUS, ST_IGNORE
  } ospi_state_e;

  function automatic logic [7:0] status_byte(input logic wel);
    status_byte = 8'h00;
    status_byte[WEL_BIT] = wel;
  endfunction

endpackage

// File: rtl/ospi_target_ctrl_if.sv
// Host-side control signals of the OSPI pins; the data bus and strobe stay top-level inouts.
interface ospi_target_ctrl_if;
  logic cs_n;
  logic sclk;

  modport master (output cs_n, output sclk);
  modport slave  (input cs_n, input sclk);
endinterface

// File: rtl/ospi_mem_array.sv
// Byte storage for the OSPI target: synchronous write, combinational read, no reset.
module ospi_mem_array #(
  parameter int MEM_DEPTH = 256,
  localparam int AW = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/ospi_target_ctrl.sv
// OSPI memory-device target: command/address/dummy decode, byte reads and writes, status, WEL.
// Define OSPI_TARGET_DQS_EN to drive a toggling read strobe on dqs alongside read data.
module ospi_target_ctrl
  import ospi_pkg::*;
#(
  parameter int MEM_DEPTH    = 256,
  parameter int ADDR_BYTES   = 4,
  parameter int DUMMY_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  ospi_target_ctrl_if.slave   bus,
  inout  wire  [7:0]          dq,
  inout  wire                 dqs
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [31:0] ADDR_MASK =
    (ADDR_BYTES >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * ADDR_BYTES)) - 32'd1);

  ospi_state_e state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [31:0] addr_q, addr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        wel_q, wel_d;
  logic        wr_done_q, wr_done_d;
  logic        drive_q, drive_d;
  logic [7:0]  dout_q, dout_d;

  logic [31:0]   addr_shift, addr_inc;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          mem_we;
  logic          unused_sclk;

  assign unused_sclk = bus.sclk;
  assign addr_shift  = {addr_q[23:0], dq} & ADDR_MASK;
  assign addr_inc    = (addr_q + 32'd1) & ADDR_MASK;

  // Read address tracks the address being loaded this edge so data leaves with that edge.
  assign rd_addr = (state_q == ST_ADDR) ? addr_shift[AW-1:0] :
                   (state_q == ST_DATA) ? addr_inc[AW-1:0]   : addr_q[AW-1:0];

  ospi_mem_array #(.MEM_DEPTH(MEM_DEPTH)) u_mem (
    .clk     (clk),
    .we      (mem_we & rst_n),
    .wr_addr (addr_q[AW-1:0]),
    .wr_data (dq),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    wel_d     = wel_q;
    wr_done_d = wr_done_q;
    drive_d   = drive_q;
    dout_d    = dout_q;
    mem_we    = 1'b0;
    if (bus.cs_n) begin
      state_d = ST_IDLE;
      drive_d = 1'b0;
      cnt_d   = '0;
      if (wr_done_q) begin
        wel_d     = 1'b0;
        wr_done_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_CMD;
        ST_CMD: begin
          cmd_d  = dq;
          addr_d = '0;
          cnt_d  = '0;
          state_d = ST_IGNORE;
          if (dq == OSPI_CMD_READ || dq == OSPI_CMD_FAST_READ || dq == OSPI_CMD_WRITE) begin
            state_d = ST_ADDR;
          end else if (dq == OSPI_CMD_READ_STATUS) begin
            state_d = ST_STATUS;
            drive_d = 1'b1;
            dout_d  = status_byte(wel_q);
          end else if (dq == OSPI_CMD_WREN) begin
            wel_d = 1'b1;
          end else if (dq == OSPI_CMD_WRDI) begin
            wel_d = 1'b0;
          end
        end
        ST_ADDR: begin
          addr_d = addr_shift;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'(ADDR_BYTES - 1)) begin
            cnt_d = '0;
            if (cmd_q == OSPI_CMD_FAST_READ) begin
              state_d = ST_DUMMY;
            end else begin
              state_d = ST_DATA;
              if (cmd_q == OSPI_CMD_READ) begin
                drive_d = 1'b1;
                dout_d  = rd_data;
              end
            end
          end
        end
        ST_DUMMY: begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(DUMMY_CYCLES - 1)) begin
            cnt_d   = '0;
            state_d = ST_DATA;
            drive_d = 1'b1;
            dout_d  = rd_data;
          end
        end
        ST_DATA: begin
          addr_d = addr_inc;
          if (cmd_q == OSPI_CMD_WRITE) begin
            // Without WEL the byte is dropped but the burst address still advances.
            if (wel_q) begin
              mem_we    = 1'b1;
              wr_done_d = 1'b1;
            end
          end else begin
            dout_d = rd_data;
          end
        end
        ST_STATUS: dout_d = status_byte(wel_q);
        ST_IGNORE: ;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      wel_q     <= 1'b0;
      wr_done_q <= 1'b0;
      drive_q   <= 1'b0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      wel_q     <= wel_d;
      wr_done_q <= wr_done_d;
      drive_q   <= drive_d;
      dout_q    <= dout_d;
    end
  end

  assign dq = drive_q ? dout_q : 8'hzz;

`ifdef OSPI_TARGET_DQS_EN
  logic dqs_q, dqs_d;

  // Strobe flips with every presented byte, so the first byte of a burst carries dqs=1.
  assign dqs_d = drive_d ? ~dqs_q : 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) dqs_q <= 1'b0;
    else        dqs_q <= dqs_d;
  end

  assign dqs = drive_q ? dqs_q : 1'bz;
`else
  assign dqs = 1'bz;
`endif

endmodule

// File: tb/tb_ospi_target_ctrl.sv
// Directed bench for ospi_target_ctrl: per-cycle expectations queued by the driver, checked by a monitor.
module tb_ospi_target_ctrl;
  import ospi_pkg::*;

  localparam int AB = 3;
  localparam int DC = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tb_oe = 1'b0;
  logic [7:0] tb_dq = 8'h00;
  wire  [7:0] dq;
  wire        dqs;

  always #5 clk = ~clk;

  ospi_target_ctrl_if bus ();
  assign bus.sclk = clk;
  initial bus.cs_n = 1'b1;

  assign dq = tb_oe ? tb_dq : 8'hzz;
  pullup   (dq);
  pulldown (dqs);

  ospi_target_ctrl #(.MEM_DEPTH(256), .ADDR_BYTES(AB), .DUMMY_CYCLES(DC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .dq    (dq),
    .dqs   (dqs)
  );

  typedef struct packed {
    logic       drv;
    logic [7:0] dq;
    logic       dqs;
  } exp_t;

  exp_t  q_exp [$];
  string q_nm  [$];
  int    checks = 0;
  int    errors = 0;

  // Released bus reads as the pull value: dq=FF, dqs=0.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (q_exp.size() != 0) begin
        exp_t       e;
        string      nm;
        logic [7:0] want_dq;
        logic       want_dqs;
        e  = q_exp.pop_front();
        nm = q_nm.pop_front();
        want_dq = e.drv ? e.dq : 8'hFF;
`ifdef OSPI_TARGET_DQS_EN
        want_dqs = e.drv ? e.dqs : 1'b0;
`else
        want_dqs = 1'b0;
`endif
        checks++;
        if (dq !== want_dq || dqs !== want_dqs) begin
          errors++;
          $display("FAIL %s: got dq=%02h dqs=%b, expected dq=%02h dqs=%b",
                   nm, dq, dqs, want_dq, want_dqs);
        end
      end
    end
  end

  task automatic cyc(input logic cs, input logic oe, input logic [7:0] v,
                     input logic drv, input logic [7:0] exp, input logic edqs,
                     input string nm);
    @(negedge clk);
    bus.cs_n = cs;
    tb_oe    = oe;
    tb_dq    = v;
    q_exp.push_back('{drv: drv, dq: exp, dqs: edqs});
    q_nm.push_back(nm);
    @(posedge clk);
    #1 tb_oe = 1'b0;
  endtask

  task automatic start(input logic [7:0] op, input logic drv, input logic [7:0] exp);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, "edge1_released");
    cyc(1'b0, 1'b1, op, drv, exp, 1'b1, "cmd_edge");
  endtask

  task automatic end_tx();
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, "cs_high_released");
  endtask

  task automatic send_addr(input logic [31:0] a, input int nbytes,
                           input logic last_drv, input logic [7:0] exp);
    for (int i = AB - 1; i >= AB - nbytes; i--) begin
      logic [7:0] b;
      b = a[8*i +: 8];
      cyc(1'b0, 1'b1, b, (i == 0) && last_drv, exp, 1'b1, "addr");
    end
  endtask

  task automatic read_tx(input logic [31:0] a, input logic [2:0][7:0] d, input int n);
    start(OSPI_CMD_READ, 1'b0, 8'h00);
    send_addr(a, AB, 1'b1, d[0]);
    for (int k = 1; k < n; k++) cyc(1'b0, 1'b0, 8'h00, 1'b1, d[k], ~k[0], "read_data");
    end_tx();
  endtask

  task automatic fast_read_tx(input logic [31:0] a, input logic [2:0][7:0] d, input int n);
    start(OSPI_CMD_FAST_READ, 1'b0, 8'h00);
    send_addr(a, AB, 1'b0, 8'h00);
    for (int i = 0; i < DC; i++) cyc(1'b0, 1'b0, 8'h00, i == DC - 1, d[0], 1'b1, "dummy");
    for (int k = 1; k < n; k++) cyc(1'b0, 1'b0, 8'h00, 1'b1, d[k], ~k[0], "fast_data");
    end_tx();
  endtask

  task automatic write_tx(input logic [31:0] a, input logic [2:0][7:0] d, input int n);
    start(OSPI_CMD_WRITE, 1'b0, 8'h00);
    send_addr(a, AB, 1'b0, 8'h00);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, d[k], 1'b0, 8'h00, 1'b0, "write_data");
    end_tx();
  endtask

  task automatic status_tx(input logic [7:0] exp);
    start(OSPI_CMD_READ_STATUS, 1'b1, exp);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, exp, 1'b0, "status_rep");
    cyc(1'b0, 1'b0, 8'h00, 1'b1, exp, 1'b1, "status_rep");
    end_tx();
  endtask

  task automatic simple_cmd(input logic [7:0] op);
    start(op, 1'b0, 8'h00);
    end_tx();
  endtask

  initial begin
    // Reset dominates an asserted chip select.
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, "reset_idle");
    cyc(1'b0, 1'b1, OSPI_CMD_WREN, 1'b0, 8'h00, 1'b0, "reset_cs_low");
    cyc(1'b0, 1'b1, OSPI_CMD_READ_STATUS, 1'b0, 8'h00, 1'b0, "reset_cs_low");
    rst_n = 1'b1;
    end_tx();
    status_tx(8'h00);

    simple_cmd(OSPI_CMD_WREN);
    status_tx(8'h02);
    write_tx(32'h10, {8'h3C, 8'h5A, 8'hA5}, 3);
    status_tx(8'h00);
    read_tx(32'h10, {8'h3C, 8'h5A, 8'hA5}, 3);

    write_tx(32'h20, {8'h00, 8'h00, 8'hFF}, 1);
    read_tx(32'h20, {8'h00, 8'h00, 8'h00}, 1);

    fast_read_tx(32'h10, {8'h3C, 8'h5A, 8'hA5}, 3);

    simple_cmd(OSPI_CMD_WREN);
    write_tx(32'hFF, {8'h00, 8'h22, 8'h11}, 2);
    read_tx(32'hFF, {8'h00, 8'h22, 8'h11}, 2);
    read_tx(32'h00, {8'h00, 8'h00, 8'h22}, 1);

    simple_cmd(OSPI_CMD_WREN);
    simple_cmd(OSPI_CMD_WRDI);
    status_tx(8'h00);

    // Unknown opcode: bus stays released even while the host keeps clocking bytes.
    start(8'h9F, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, OSPI_CMD_READ, 1'b0, 8'h00, 1'b0, "ignore");
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, "ignore");
    cyc(1'b0, 1'b1, 8'h10, 1'b0, 8'h00, 1'b0, "ignore");
    end_tx();

    // Abort mid-address, then a clean read still sees the stored byte.
    start(OSPI_CMD_READ, 1'b0, 8'h00);
    send_addr(32'h10, AB - 1, 1'b0, 8'h00);
    end_tx();
    read_tx(32'h10, {8'h3C, 8'h5A, 8'hA5}, 1);

    // Reset in the middle of a read burst with WEL set.
    simple_cmd(OSPI_CMD_WREN);
    start(OSPI_CMD_READ, 1'b0, 8'h00);
    send_addr(32'h10, AB, 1'b1, 8'hA5);
    rst_n = 1'b0;
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, "reset_mid_read");
    rst_n = 1'b1;
    end_tx();
    status_tx(8'h00);

    end_tx();
    @(posedge clk);
    #3;
    checks++;
    if (q_exp.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", q_exp.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
